// File: rtl/gas_fsm_pkg.sv
// gas_fsm_pkg: zone state codes, state width and buzzer-state decode shared by the gas FSM blocks
package gas_fsm_pkg;
  localparam int ST_W = 3;
  typedef enum logic [ST_W-1:0] {
    STANDBY  = 3'd0,
    HAZARD   = 3'd1,
    FAULT    = 3'd2,
    WAIT_RST = 3'd3,
    FS_PF    = 3'd4,
    HZ_PF    = 3'd5
  } state_t;
  function automatic logic is_buzz(state_t s);
    return s == HAZARD || s == FAULT || s == HZ_PF;
  endfunction
endpackage

// File: rtl/gas_zone_ctrl.sv
// gas_zone_ctrl: one zone's gas debounce, fan grace counter, hazard FSM and actuator decode (GAS_FSM_EVENT_CNT_EN adds evt)
module gas_zone_ctrl
  import gas_fsm_pkg::*;
#(
  parameter int DEB_CYCLES = 3,
  parameter int FAN_GRACE  = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   gas_ok,
  input  logic   fan_ok,
  input  logic   pf,
  input  logic   rfid,
  output state_t st,
  output logic   vent_on,
  output logic   valve_shut
`ifdef GAS_FSM_EVENT_CNT_EN
  ,
  output logic [7:0] evt
`endif
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int CW = $clog2(FAN_GRACE + 1);
  logic          gf;
  logic [DW-1:0] dc;
  logic [CW-1:0] fc;
  logic          lk;
  state_t        nxt;
  assign lk = ~gf;
  always_comb begin
    nxt = st;
    case (st)
      STANDBY:  nxt = pf ? FS_PF : lk ? HAZARD : STANDBY;
      HAZARD:   nxt = pf ? HZ_PF : (fc == CW'(FAN_GRACE)) ? FAULT : !lk ? WAIT_RST : HAZARD;
      FAULT:    nxt = pf ? HZ_PF : (!lk && fan_ok) ? WAIT_RST : FAULT;
      HZ_PF:    nxt = !pf ? FAULT : HZ_PF;
      FS_PF:    nxt = lk ? HZ_PF : !pf ? STANDBY : FS_PF;
      WAIT_RST: nxt = lk ? HAZARD : rfid ? STANDBY : WAIT_RST;
      default:  nxt = HAZARD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gf         <= 1'b1;
      dc         <= '0;
      fc         <= '0;
      st         <= STANDBY;
      vent_on    <= 1'b0;
      valve_shut <= 1'b0;
    end else begin
      if (gas_ok == gf) dc <= '0;
      else if (dc == DW'(DEB_CYCLES - 1)) begin
        gf <= gas_ok;
        dc <= '0;
      end else dc <= dc + 1'b1;
      fc         <= (st != HAZARD || fan_ok) ? '0 : (fc == CW'(FAN_GRACE)) ? fc : fc + 1'b1;
      st         <= nxt;
      vent_on    <= nxt == HAZARD || nxt == FAULT;
      valve_shut <= nxt != STANDBY;
    end
  end
`ifdef GAS_FSM_EVENT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) evt <= '0;
    else if (evt != 8'hff && (((st == STANDBY || st == WAIT_RST) && nxt == HAZARD) || (st == FS_PF && nxt == HZ_PF)))
      evt <= evt + 8'd1;
  end
`endif
endmodule

// File: rtl/gas_fsm_multi.sv
// gas_fsm_multi: multi-zone gas-leak controller with shared power filter and site-level alarm aggregation
// Optional GAS_FSM_EVENT_CNT_EN adds per-zone hazard-entry counters on evt_cnt.
module gas_fsm_multi
  import gas_fsm_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int DEB_CYCLES = 3,
  parameter int FAN_GRACE  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_ZONES-1:0]      gas_ok,
  input  logic [N_ZONES-1:0]      fan_ok,
  input  logic                    pwr_ok,
  input  logic                    rfid_ok,
  input  logic [N_ZONES-1:0]      rst_mask,
  output logic [N_ZONES-1:0]      vent_on,
  output logic [N_ZONES-1:0]      valve_shut,
  output logic [ST_W*N_ZONES-1:0] zone_state,
  output logic                    buzzer,
  output logic                    strobe,
  output logic                    fault_led,
  output logic                    ups_sel
`ifdef GAS_FSM_EVENT_CNT_EN
  ,
  output logic [8*N_ZONES-1:0]    evt_cnt
`endif
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  logic          pfl;
  logic [DW-1:0] pdc;
  state_t        st [N_ZONES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pfl <= 1'b1;
      pdc <= '0;
    end else if (pwr_ok == pfl) pdc <= '0;
    else if (pdc == DW'(DEB_CYCLES - 1)) begin
      pfl <= pwr_ok;
      pdc <= '0;
    end else pdc <= pdc + 1'b1;
  end
  assign ups_sel = ~pfl;
  genvar i;
  generate
    for (i = 0; i < N_ZONES; i++) begin : g_zone
      gas_zone_ctrl #(.DEB_CYCLES(DEB_CYCLES), .FAN_GRACE(FAN_GRACE)) u_zone (
        .clk       (clk),
        .rst_n     (rst_n),
        .gas_ok    (gas_ok[i]),
        .fan_ok    (fan_ok[i]),
        .pf        (ups_sel),
        .rfid      (rfid_ok & rst_mask[i]),
        .st        (st[i]),
        .vent_on   (vent_on[i]),
        .valve_shut(valve_shut[i])
`ifdef GAS_FSM_EVENT_CNT_EN
        ,
        .evt       (evt_cnt[8*i+:8])
`endif
      );
      assign zone_state[ST_W*i+:ST_W] = st[i];
    end
  endgenerate
  always_comb begin
    buzzer    = 1'b0;
    strobe    = 1'b0;
    fault_led = 1'b0;
    for (int k = 0; k < N_ZONES; k++) begin
      buzzer    |= is_buzz(st[k]);
      strobe    |= !(st[k] == STANDBY || st[k] == FS_PF);
      fault_led |= st[k] == FAULT || st[k] == HZ_PF;
    end
  end
endmodule

// File: tb/tb_gas_fsm_multi.sv
// tb_gas_fsm_multi: table-driven directed bench for gas_fsm_multi (N_ZONES=4, DEB_CYCLES=3, FAN_GRACE=8)
module tb_gas_fsm_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  gas_ok = 4'hf, fan_ok = 4'hf, rst_mask = 4'h0;
  logic        pwr_ok = 1'b1, rfid_ok = 1'b0;
  logic [3:0]  vent_on, valve_shut;
  logic [11:0] zone_state;
  logic        buzzer, strobe, fault_led, ups_sel;
`ifdef GAS_FSM_EVENT_CNT_EN
  logic [31:0] evt_cnt;
`endif
  int checks = 0, errors = 0;

  gas_fsm_multi #(.N_ZONES(4), .DEB_CYCLES(3), .FAN_GRACE(8)) dut (
    .clk(clk), .rst_n(rst_n), .gas_ok(gas_ok), .fan_ok(fan_ok), .pwr_ok(pwr_ok),
    .rfid_ok(rfid_ok), .rst_mask(rst_mask), .vent_on(vent_on), .valve_shut(valve_shut),
    .zone_state(zone_state), .buzzer(buzzer), .strobe(strobe), .fault_led(fault_led),
    .ups_sel(ups_sel)
`ifdef GAS_FSM_EVENT_CNT_EN
    , .evt_cnt(evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gas, fan;
    logic        pwr, rfid;
    logic [3:0]  mask;
    int          cyc;
    logic [11:0] zs;
    logic [3:0]  vent, valve;
    logic        buz, stb, flt, ups;
  } vec_t;

  vec_t tv[24];

  function automatic vec_t mk(logic [3:0] g, logic [3:0] f, logic p, logic r, logic [3:0] m, int c,
                              logic [11:0] zs, logic [3:0] ve, logic [3:0] va,
                              logic b, logic s, logic fl, logic u);
    vec_t v;
    v.gas = g; v.fan = f; v.pwr = p; v.rfid = r; v.mask = m; v.cyc = c;
    v.zs = zs; v.vent = ve; v.valve = va; v.buz = b; v.stb = s; v.flt = fl; v.ups = u;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(int idx, logic [11:0] zs, logic [3:0] ve, logic [3:0] va,
                         logic b, logic s, logic fl, logic u);
    chk("zone_state", idx, 32'(zone_state), 32'(zs));
    chk("vent_on", idx, 32'(vent_on), 32'(ve));
    chk("valve_shut", idx, 32'(valve_shut), 32'(va));
    chk("buzzer", idx, 32'(buzzer), 32'(b));
    chk("strobe", idx, 32'(strobe), 32'(s));
    chk("fault_led", idx, 32'(fault_led), 32'(fl));
    chk("ups_sel", idx, 32'(ups_sel), 32'(u));
  endtask

  initial begin
    // gas   fan    pwr rfid mask cyc  zone_state vent valve buz stb flt ups
    tv[0]  = mk(4'b1110, 4'hf, 1, 0, 4'h0, 2, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    tv[1]  = mk(4'b1110, 4'hf, 1, 0, 4'h0, 1, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    tv[2]  = mk(4'b1110, 4'hf, 1, 0, 4'h0, 1, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[3]  = mk(4'b1100, 4'hf, 1, 0, 4'h0, 2, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[4]  = mk(4'b1110, 4'hf, 1, 0, 4'h0, 4, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[5]  = mk(4'b1110, 4'he, 1, 0, 4'h0, 7, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[6]  = mk(4'b1110, 4'hf, 1, 0, 4'h0, 2, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[7]  = mk(4'b1110, 4'he, 1, 0, 4'h0, 8, 12'h001, 4'h1, 4'h1, 1, 1, 0, 0);
    tv[8]  = mk(4'b1110, 4'he, 1, 0, 4'h0, 1, 12'h002, 4'h1, 4'h1, 1, 1, 1, 0);
    tv[9]  = mk(4'b1110, 4'he, 0, 0, 4'h0, 2, 12'h002, 4'h1, 4'h1, 1, 1, 1, 0);
    tv[10] = mk(4'b1110, 4'he, 0, 0, 4'h0, 1, 12'h002, 4'h1, 4'h1, 1, 1, 1, 1);
    tv[11] = mk(4'b1110, 4'he, 0, 0, 4'h0, 1, 12'h925, 4'h0, 4'hf, 1, 1, 1, 1);
    tv[12] = mk(4'b1110, 4'he, 1, 0, 4'h0, 2, 12'h925, 4'h0, 4'hf, 1, 1, 1, 1);
    tv[13] = mk(4'b1110, 4'he, 1, 0, 4'h0, 1, 12'h925, 4'h0, 4'hf, 1, 1, 1, 0);
    tv[14] = mk(4'b1110, 4'he, 1, 0, 4'h0, 1, 12'h002, 4'h1, 4'h1, 1, 1, 1, 0);
    tv[15] = mk(4'b1111, 4'hf, 1, 0, 4'h0, 3, 12'h002, 4'h1, 4'h1, 1, 1, 1, 0);
    tv[16] = mk(4'b1111, 4'hf, 1, 0, 4'h0, 1, 12'h003, 4'h0, 4'h1, 0, 1, 0, 0);
    tv[17] = mk(4'b1111, 4'hf, 1, 1, 4'h2, 1, 12'h003, 4'h0, 4'h1, 0, 1, 0, 0);
    tv[18] = mk(4'b1111, 4'hf, 1, 0, 4'h2, 1, 12'h003, 4'h0, 4'h1, 0, 1, 0, 0);
    tv[19] = mk(4'b1111, 4'hf, 1, 1, 4'h1, 1, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    tv[20] = mk(4'b1111, 4'hf, 1, 0, 4'h0, 2, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    tv[21] = mk(4'b1010, 4'hb, 1, 0, 4'h0, 4, 12'h041, 4'h5, 4'h5, 1, 1, 0, 0);
    tv[22] = mk(4'b1010, 4'hb, 1, 0, 4'h0, 8, 12'h041, 4'h5, 4'h5, 1, 1, 0, 0);
    tv[23] = mk(4'b1010, 4'hb, 1, 0, 4'h0, 1, 12'h081, 4'h5, 4'h5, 1, 1, 1, 0);

    #2 rst_n = 1'b0;
    step(2);
    chk_all(-1, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int r = 0; r < 24; r++) begin
      gas_ok = tv[r].gas; fan_ok = tv[r].fan; pwr_ok = tv[r].pwr;
      rfid_ok = tv[r].rfid; rst_mask = tv[r].mask;
      step(tv[r].cyc);
      chk_all(r, tv[r].zs, tv[r].vent, tv[r].valve, tv[r].buz, tv[r].stb, tv[r].flt, tv[r].ups);
    end

    // asynchronous reset mid-cycle, observed before any further clock edge
    gas_ok = 4'hf; fan_ok = 4'hf;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all(100, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(5);
    chk_all(101, 12'h000, 4'h0, 4'h0, 0, 0, 0, 0);

`ifdef GAS_FSM_EVENT_CNT_EN
    rst_mask = 4'h8;
    for (int n = 0; n < 300; n++) begin
      gas_ok = 4'b0111;
      step(4);
      gas_ok = 4'hf;
      step(4);
      rfid_ok = 1'b1;
      step(1);
      rfid_ok = 1'b0;
      if (n == 0) chk("evt_first", 200, evt_cnt, 32'h0100_0000);
    end
    chk("evt_sat", 201, evt_cnt, 32'hff00_0000);
    chk("evt_state", 202, 32'(zone_state), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
